duty_ramp: RTL
==============

// Module: duty_ramp
// PURPOSE
//  Slew-rate limiter directly upstream of the DC-motor PWM generator.
//  Accepts a signed 14-bit target duty from the control logic and steps the
//  duty output toward it by at most STEP per update tick.
//  Emits duty[13:0] plus a one-cycle wrt_duty strobe that feed the PWM
//  generator's duty/wrt_duty inputs. This prevents current surges on motor
//  start and on direction reversal.
// PARAMETERS
//  STEP      13'd64  max |duty change| per update tick
//  UPD_DIV   8192    clk cycles per update tick; >=8192 so the PWM gets one
//                    full 13-bit period between writes
//  DWELL     4       update ticks held at duty=0 on sign reversal
//                    (ZERO_DWELL_EN only)
// PORTS
//  clk       in   1   system clock
//  rst       in   1   synchronous reset, active-high
//  tgt       in   14  target duty, two's complement
//  tgt_vld   in   1   tgt is captured on any clk edge where tgt_vld=1
//  duty      out  14  current ramped duty, two's complement, registered
//  wrt_duty  out  1   1-cycle pulse; duty holds the new value in the same cycle
//  at_tgt    out  1   1 when duty==captured target and no dwell is pending
// BEHAVIOUR
//  Reset (rst=1 at a posedge): duty=0, tgt_q=0, wrt_duty=0, at_tgt=1,
//   prescaler=0, state=IDLE. Reset mid-ramp aborts the ramp; no wrt_duty is issued.
//  Capture: tgt_q <= clamp(tgt) when tgt_vld=1. clamp maps -8192 to -8191,
//   because the PWM generator's 13-bit magnitude cannot represent 8192.
//   A new target is accepted in any state; the prescaler is NOT restarted.
//  Prescaler: counts 0..UPD_DIV-1 free-running; tick=1 on UPD_DIV-1, then wraps to 0.
//  Step, on tick only:
//   diff = tgt_q - duty, computed at 15 bits signed.
//   If |diff|<=STEP, duty<=tgt_q; else duty<=duty+STEP*sign(diff).
//   wrt_duty=1 on the cycle after the tick, only if duty changed.
//   No strobe when duty already equals tgt_q.
//  Latency: tgt_vld -> first duty change is <= UPD_DIV+1 cycles.
//  Simultaneous tgt_vld and tick: the step uses the old tgt_q; the new target
//   applies from the next tick.
//  FSM states:
//   IDLE  duty==tgt_q; at_tgt=1; waits for tgt_q!=duty.
//   RAMP  stepping on ticks; goes to IDLE when the step lands on tgt_q.
//   DWELL (ZERO_DWELL_EN only) duty held at 0; dwell counter decrements on
//         ticks; goes to RAMP when it reaches 0.
//   IDLE->RAMP on the cycle after tgt_q!=duty is detected.
//   Retargeting to the current duty during RAMP returns the FSM to IDLE.
//  No wrap: duty stays within [-8191,8191] by construction; no overflow is possible.
// CONFIGURATION
//  ZERO_DWELL_EN defined:
//   - A step whose result would change duty's nonzero sign instead sets duty=0,
//     issues wrt_duty, loads the dwell counter with DWELL and enters DWELL.
//   - Retarget during DWELL to the same sign as the pre-dwell duty: the FSM
//     still finishes the dwell.
//   - Retarget to 0 during DWELL: at_tgt asserts once the dwell expires.
//  ZERO_DWELL_EN undefined:
//   - No DWELL state. A step may cross zero directly, e.g. 32 -> -32 with STEP=64.
// STRUCTURE
//  Package motor_pkg:
//   - typedef logic signed [13:0] duty_t
//   - localparam DUTY_MAX = 14'sd8191, DUTY_MIN = -14'sd8191
//   - typedef enum {IDLE, RAMP, DWELL} ramp_state_t
//  Sub-module tick_gen: parameterised prescaler (clk, rst -> tick).
//   Reused by other timebases in the design.
// TESTING
//  T1 reset: rst=1 for 2 cycles, then rst=0 -> duty=0, wrt_duty=0, at_tgt=1,
//     and no strobe for 3*UPD_DIV cycles.
//  T2 ramp up: tgt=200 -> duty 64,128,192,200 on four consecutive ticks.
//     Exactly 4 wrt_duty pulses, then at_tgt=1.
//  T3 clamp: tgt=14'h2000 (-8192) -> ramp settles at -8191, never -8192.
//  T4 retarget: mid-ramp at duty=128, set tgt=0 -> next ticks give 64, 0; at_tgt=1.
//     tgt_vld on a tick cycle: that step uses the old target.
//  T5 reversal, ZERO_DWELL_EN set: duty=32, tgt=-100 -> 0 (strobe), 4 silent
//     ticks, then -64, -100.
//     Same stimulus with the macro undefined -> -32, -96, -100.
//  T6 reset mid-ramp: rst=1 at duty=128 -> next cycle duty=0, wrt_duty=0, at_tgt=1.
//     The bench PWM model's CH_A and CH_B stay low.

Source files
------------

// File: rtl/duty_ramp_pkg.sv
// motor_pkg: duty type, duty limits, ramp FSM state names and the target clamp.
// Shared by the duty_ramp slice and the PWM-side logic.
package motor_pkg;

    typedef logic signed [13:0] duty_t;

    localparam duty_t DUTY_MAX = 14'sd8191;
    localparam duty_t DUTY_MIN = -14'sd8191;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        DWELL = 2'd2
    } ramp_state_t;

    // The PWM magnitude is 13 bits, so -8192 has no representation there.
    function automatic duty_t clamp_duty(input duty_t v);
        if (v < DUTY_MIN) begin
            return DUTY_MIN;
        end
        if (v > DUTY_MAX) begin
            return DUTY_MAX;
        end
        return v;
    endfunction

endpackage

// File: rtl/duty_ramp_if.sv
// duty_ramp_if: target input and ramped duty output between control logic and
// the slew limiter. master = control logic, slave = duty_ramp.
interface duty_ramp_if;
    import motor_pkg::*;

    duty_t tgt;
    logic  tgt_vld;
    duty_t duty;
    logic  wrt_duty;
    logic  at_tgt;

    modport master (
        output tgt,
        output tgt_vld,
        input  duty,
        input  wrt_duty,
        input  at_tgt
    );

    modport slave (
        input  tgt,
        input  tgt_vld,
        output duty,
        output wrt_duty,
        output at_tgt
    );

endinterface

// File: rtl/duty_ramp_tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick every DIV clocks.
// Counts 0..DIV-1; tick is high while the count sits at DIV-1.
module tick_gen #(
    parameter int unsigned DIV = 8192
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(DIV - 1));

    // Prescaler count, wrapping to zero on the tick cycle.
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/duty_ramp.sv
// duty_ramp: slew-rate limiter feeding the DC-motor PWM generator.
// Steps duty toward the captured target by at most STEP per update tick.
// Optional feature: define ZERO_DWELL_EN to hold duty at 0 for DWELL ticks
// whenever a step would flip the sign of a nonzero duty.
module duty_ramp #(
    parameter int unsigned STEP    = 64,
    parameter int unsigned UPD_DIV = 8192,
    parameter int unsigned DWELL   = 4
) (
    input  logic        clk,
    input  logic        rst,
    duty_ramp_if.slave  bus
);
    import motor_pkg::*;

    localparam logic [1:0] S_IDLE = motor_pkg::IDLE;
    localparam logic [1:0] S_RAMP = motor_pkg::RAMP;
`ifdef ZERO_DWELL_EN
    localparam logic [1:0] S_DWELL = motor_pkg::DWELL;
    localparam logic [7:0] DWELL_W = 8'(DWELL);
`endif
    localparam logic [14:0] STEP_W = 15'(STEP);
    localparam duty_t       STEP_D = duty_t'(STEP);

    logic              tick;
    logic [1:0]        state_q, state_d;
    duty_t             duty_q, duty_d;
    duty_t             tgt_q, tgt_d;
    logic              wrt_q, wrt_d;
    duty_t             step_val;
    logic signed [14:0] diff;
    logic [14:0]       diff_mag;
`ifdef ZERO_DWELL_EN
    logic [7:0]        dwell_q, dwell_d;
    logic              crosses;
`endif

    tick_gen #(
        .DIV (UPD_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Candidate step toward the held target, using a 15-bit difference.
    always_comb begin
        diff     = {tgt_q[13], tgt_q} - {duty_q[13], duty_q};
        diff_mag = diff[14] ? $unsigned(-diff) : $unsigned(diff);
        if (diff_mag <= STEP_W) begin
            step_val = tgt_q;
        end else if (diff[14]) begin
            step_val = duty_q - STEP_D;
        end else begin
            step_val = duty_q + STEP_D;
        end
`ifdef ZERO_DWELL_EN
        crosses = (duty_q != '0) && (step_val != '0) && (step_val[13] != duty_q[13]);
`endif
    end

    // FSM, duty update and write strobe.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        wrt_d   = 1'b0;
        tgt_d   = bus.tgt_vld ? clamp_duty(bus.tgt) : tgt_q;
`ifdef ZERO_DWELL_EN
        dwell_d = dwell_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tgt_q != duty_q) begin
                    state_d = S_RAMP;
                end
            end
            S_RAMP: begin
                if (tick) begin
`ifdef ZERO_DWELL_EN
                    if (crosses) begin
                        duty_d  = '0;
                        wrt_d   = 1'b1;
                        dwell_d = DWELL_W;
                        state_d = S_DWELL;
                    end else
`endif
                    begin
                        duty_d = step_val;
                        wrt_d  = (step_val != duty_q);
                        if (step_val == tgt_q) begin
                            state_d = S_IDLE;
                        end
                    end
                end else if (tgt_q == duty_q) begin
                    state_d = S_IDLE;
                end
            end
`ifdef ZERO_DWELL_EN
            S_DWELL: begin
                if (tick) begin
                    dwell_d = dwell_q - 8'd1;
                    if (dwell_q <= 8'd1) begin
                        state_d = (tgt_q == duty_q) ? S_IDLE : S_RAMP;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any ramp in progress without a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            wrt_q   <= 1'b0;
`ifdef ZERO_DWELL_EN
            dwell_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            wrt_q   <= wrt_d;
`ifdef ZERO_DWELL_EN
            dwell_q <= dwell_d;
`endif
        end
    end

    assign bus.duty     = duty_q;
    assign bus.wrt_duty = wrt_q;
`ifdef ZERO_DWELL_EN
    assign bus.at_tgt   = (duty_q == tgt_q) && (state_q != S_DWELL);
`else
    assign bus.at_tgt   = (duty_q == tgt_q);
`endif

endmodule
